// File: rtl/reg_bus_pkg.sv
// Shared types and defaults for the register-bus initiator.
package reg_bus_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    localparam int TO_W_DEF   = 16;

    typedef enum logic [1:0] {
        OP_WR   = 2'b00,
        OP_RD   = 2'b01,
        OP_POLL = 2'b10,
        OP_ILL  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_TIMEOUT = 2'b01,
        ST_ILLEGAL = 2'b10
    } status_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_RD   = 3'd2,
        S_POLL = 3'd3,
        S_RESP = 3'd4
    } state_t;

endpackage

// File: rtl/reg_bus_master.sv
// Register-bus initiator: accepts one write/read/poll command at a time,
// runs the bus cycle(s) and returns read data plus status.
module reg_bus_master
    import reg_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int TO_W   = TO_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [DATA_W-1:0] cmd_mask,
    input  logic [TO_W-1:0]   cmd_limit,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_status,
    output logic              busy,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata
);

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mask_q;
    logic [TO_W-1:0]   limit_q;
    logic [TO_W-1:0]   cnt_q;
    logic [DATA_W-1:0] rdata_q;
    status_t           status_q;

    logic [TO_W:0]     cnt_next;
    logic [TO_W-1:0]   limit_eff;
    logic              poll_match;
    logic              poll_last;

    // A limit of 0 behaves as 1; the extra counter bit keeps the compare exact.
    assign limit_eff  = (limit_q == '0) ? {{(TO_W-1){1'b0}}, 1'b1} : limit_q;
    assign cnt_next   = {1'b0, cnt_q} + {{TO_W{1'b0}}, 1'b1};
    assign poll_last  = (cnt_next >= {1'b0, limit_eff});
    assign poll_match = (((rdata ^ wdata_q) & mask_q) == '0);

    assign rsp_rdata  = rdata_q;
    assign rsp_status = status_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of block ordering.
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state decode and bus/handshake outputs.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_next = state;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        addr       = '0;
        wdata      = '0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    case (op_t'(cmd_op))
                        OP_WR:   state_next = S_WR;
                        OP_RD:   state_next = S_RD;
                        OP_POLL: state_next = S_POLL;
                        default: state_next = S_RESP;
                    endcase
                end
            end
            S_WR: begin
                wr_en      = 1'b1;
                addr       = addr_q;
                wdata      = wdata_q;
                state_next = S_RESP;
            end
            S_RD: begin
                rd_en      = 1'b1;
                addr       = addr_q;
                state_next = S_RESP;
            end
            S_POLL: begin
                rd_en = 1'b1;
                addr  = addr_q;
                if (poll_match || poll_last) state_next = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Command latch, poll counter and response capture.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: datapath registers are reset too, since rsp_rdata/rsp_status
        // are driven straight from them and must read 0 out of reset.
        if (rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            mask_q   <= '0;
            limit_q  <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            status_q <= ST_OK;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        addr_q   <= cmd_addr;
                        wdata_q  <= cmd_wdata;
                        mask_q   <= cmd_mask;
                        limit_q  <= cmd_limit;
                        cnt_q    <= '0;
                        rdata_q  <= '0;
                        status_q <= (op_t'(cmd_op) == OP_ILL) ? ST_ILLEGAL : ST_OK;
                    end
                end
                S_RD: begin
                    rdata_q <= rdata;
                end
                S_POLL: begin
                    rdata_q <= rdata;
                    cnt_q   <= cnt_next[TO_W-1:0];
                    // A match on the final allowed read still reports OK.
                    if (!poll_match && poll_last) status_q <= ST_TIMEOUT;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed bench for reg_bus_master driving a small regset model
// (DATA0 at 0x0 read/write, read-only mirror of DATA0 at 0x4, others read 0).
module tb_reg_bus_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [9:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [31:0] cmd_mask;
    logic [15:0] cmd_limit;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_status;
    logic        busy;
    logic        wr_en;
    logic        rd_en;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  status;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Bus monitor counters.
    int wr_cnt = 0;
    int rd_cnt = 0;
    int both_cnt = 0;
    int idle_nz_cnt = 0;
    logic [9:0]  last_waddr = '0;
    logic [31:0] last_wdata = '0;

    // Target register model.
    logic [31:0] data0 = '0;

    always #5 clk = ~clk;

    reg_bus_master dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_mask   (cmd_mask),
        .cmd_limit  (cmd_limit),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_status (rsp_status),
        .busy       (busy),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata)
    );

    always_comb begin
        rdata = '0;
        if (rd_en && (addr == 10'h000 || addr == 10'h004)) rdata = data0;
    end

    always @(posedge clk) begin
        if (wr_en && addr == 10'h000) data0 <= wdata;
    end

    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt     = wr_cnt + 1;
            last_waddr = addr;
            last_wdata = wdata;
        end
        if (rd_en) rd_cnt = rd_cnt + 1;
        if (wr_en && rd_en) both_cnt = both_cnt + 1;
        if (!wr_en && wdata != '0) idle_nz_cnt = idle_nz_cnt + 1;
        if (!wr_en && !rd_en && addr != '0) idle_nz_cnt = idle_nz_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one command, then check latency, response, bus activity and the
    // return to IDLE. hold > 0 keeps rsp_ready low that many cycles.
    task automatic run_cmd(input string name,
                           input logic [1:0] op, input logic [9:0] a,
                           input logic [31:0] wd, input logic [31:0] mk,
                           input logic [15:0] lim,
                           input logic [31:0] exp_rdata, input logic [1:0] exp_status,
                           input int exp_wr, input int exp_rd, input int exp_lat,
                           input int hold);
        int   k;
        int   wr0, rd0;
        exp_t e;
        logic [31:0] hold_rdata;
        logic [1:0]  hold_status;
        @(negedge clk);
        cmd_op    = op;
        cmd_addr  = a;
        cmd_wdata = wd;
        cmd_mask  = mk;
        cmd_limit = lim;
        cmd_valid = 1'b1;
        rsp_ready = (hold == 0);
        sb_q.push_back('{rdata: exp_rdata, status: exp_status});
        k = 0;
        while (!cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check({name, " cmd_ready"}, 64'(cmd_ready), 64'(1));
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        @(posedge clk);
        #1;
        // Scramble the command inputs; the DUT must use its latched copy.
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_addr  = 10'($urandom);
        cmd_wdata = $urandom;
        cmd_mask  = $urandom;
        cmd_limit = 16'($urandom);
        @(negedge clk);
        k = 0;
        while (!rsp_valid && k < 300) begin
            @(negedge clk);
            k++;
        end
        check({name, " rsp_valid"}, 64'(rsp_valid), 64'(1));
        check({name, " latency"}, 64'(k), 64'(exp_lat));
        e = sb_q.pop_front();
        check({name, " rsp_rdata"}, 64'(rsp_rdata), 64'(e.rdata));
        check({name, " rsp_status"}, 64'(rsp_status), 64'(e.status));
        check({name, " busy/cmd_ready in RESP"}, {62'd0, busy, cmd_ready}, 64'b10);
        if (hold > 0) begin
            hold_rdata  = rsp_rdata;
            hold_status = rsp_status;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check({name, " hold valid/ready"}, {62'd0, rsp_valid, cmd_ready}, 64'b10);
                check({name, " hold rsp"}, {30'd0, rsp_status, rsp_rdata},
                      {30'd0, hold_status, hold_rdata});
            end
            rsp_ready = 1'b1;
        end
        #1;
        check({name, " wr_en cycles"}, 64'(wr_cnt - wr0), 64'(exp_wr));
        check({name, " rd_en cycles"}, 64'(rd_cnt - rd0), 64'(exp_rd));
        @(negedge clk);
        check({name, " back to IDLE"}, {61'd0, rsp_valid, cmd_ready, busy}, 64'b010);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_mask  = '0;
        cmd_limit = '0;
        rsp_ready = 1'b1;

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset cmd_ready", 64'(cmd_ready), 64'(1));
        check("reset outputs", {busy, rsp_valid, rsp_status, wr_en, rd_en, addr, wdata, rsp_rdata},
              '0);
        rst = 1'b0;
        @(negedge clk);
        check("post-reset idle", {61'd0, cmd_ready, busy, rsp_valid}, 64'b100);

        // Reads of a freshly reset target.
        run_cmd("rd0",  2'b01, 10'h000, '0, '0, '0, 32'h0000_0000, 2'b00, 0, 1, 1, 0);
        run_cmd("rd4",  2'b01, 10'h004, '0, '0, '0, 32'h0000_0000, 2'b00, 0, 1, 1, 0);

        // Write then read back through the mirror.
        run_cmd("wr0",  2'b00, 10'h000, 32'hAAAA_5555, '0, '0, 32'h0, 2'b00, 1, 0, 1, 0);
        check("wr addr", 64'(last_waddr), 64'(10'h000));
        check("wr data", 64'(last_wdata), 64'(32'hAAAA_5555));
        run_cmd("rd4b", 2'b01, 10'h004, '0, '0, '0, 32'hAAAA_5555, 2'b00, 0, 1, 1, 0);

        // Polls: immediate match, timeout after 3, limit 0 as 1, match on last read.
        run_cmd("poll_hit",  2'b10, 10'h004, 32'h0000_5555, 32'h0000_FFFF, 16'd8,
                32'hAAAA_5555, 2'b00, 0, 1, 1, 0);
        run_cmd("poll_to3",  2'b10, 10'h004, 32'h0000_1234, 32'h0000_FFFF, 16'd3,
                32'hAAAA_5555, 2'b01, 0, 3, 3, 0);
        run_cmd("poll_lim0", 2'b10, 10'h004, 32'h0000_1234, 32'h0000_FFFF, 16'd0,
                32'hAAAA_5555, 2'b01, 0, 1, 1, 0);
        run_cmd("poll_lim1", 2'b10, 10'h000, 32'hAAAA_0000, 32'hFFFF_0000, 16'd1,
                32'hAAAA_5555, 2'b00, 0, 1, 1, 0);

        // Write to the read-only mirror is ignored; unmapped reads 0; illegal op.
        run_cmd("wr4",   2'b00, 10'h004, 32'hFFFF_FFFF, '0, '0, 32'h0, 2'b00, 1, 0, 1, 0);
        check("wr4 addr", 64'(last_waddr), 64'(10'h004));
        run_cmd("rd0b",  2'b01, 10'h000, '0, '0, '0, 32'hAAAA_5555, 2'b00, 0, 1, 1, 0);
        run_cmd("rd100", 2'b01, 10'h100, '0, '0, '0, 32'h0000_0000, 2'b00, 0, 1, 1, 0);
        run_cmd("ill",   2'b11, 10'h004, 32'h1234_5678, '1, 16'd5, 32'h0, 2'b10, 0, 0, 0, 0);

        // Response backpressure.
        run_cmd("bp_rd", 2'b01, 10'h000, '0, '0, '0, 32'hAAAA_5555, 2'b00, 0, 1, 1, 5);

        // Reset in the middle of a long poll.
        @(negedge clk);
        cmd_op    = 2'b10;
        cmd_addr  = 10'h008;
        cmd_wdata = 32'h1;
        cmd_mask  = 32'h1;
        cmd_limit = 16'd100;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("poll in flight", {62'd0, busy, rd_en}, 64'b11);
        rst = 1'b1;
        #1;
        check("async reset cmd_ready", 64'(cmd_ready), 64'(1));
        check("async reset outputs",
              {busy, rsp_valid, rsp_status, wr_en, rd_en, addr, wdata, rsp_rdata}, '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("after reset idle", {60'd0, rsp_valid, cmd_ready, busy, rd_en}, 64'b0100);
        run_cmd("rd_after_rst", 2'b01, 10'h004, '0, '0, '0, 32'hAAAA_5555, 2'b00, 0, 1, 1, 0);

        // Whole-run bus properties and scoreboard drain.
        check("wr_en and rd_en together", 64'(both_cnt), 64'(0));
        check("bus nonzero when idle", 64'(idle_nz_cnt), 64'(0));
        check("scoreboard empty", 64'(sb_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/reg_bus_master.md
Name: reg_bus_master

Overview:
- Initiator for the team's simple register bus: `wr_en`/`rd_en`/`addr`/`wdata` out, combinational `rdata` in.
- Takes one command at a time over a valid/ready interface: write, read, or poll-until-match.
- Drives the bus cycle for each command and returns a response (read data plus status) over a valid/ready interface.
- Sits between a host/control sequencer and any `regset`-style target.

Parameters:
- ADDR_W, 10, register address width
- DATA_W, 32, register data width
- TO_W, 16, poll read-count limit width

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid && ready
- cmd_op  in  2  00 write, 01 read, 10 poll, 11 illegal
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data (write) / expected value (poll)
- cmd_mask  in  DATA_W  poll compare mask
- cmd_limit  in  TO_W  maximum poll reads; 0 treated as 1
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when valid && ready
- rsp_rdata  out  DATA_W  captured read data; 0 for write/illegal
- rsp_status  out  2  00 OK, 01 poll timeout, 10 illegal op
- busy  out  1  high whenever state != IDLE
- wr_en  out  1  bus write strobe
- rd_en  out  1  bus read strobe
- addr  out  ADDR_W  bus address
- wdata  out  DATA_W  bus write data
- rdata  in  DATA_W  bus read data, valid combinationally in the `rd_en` cycle

Behaviour:
- Reset:
  - Asynchronous; state returns to IDLE immediately.
  - `cmd_ready`=1 once IDLE.
  - All other outputs are 0: `rsp_valid`, `rsp_rdata`, `rsp_status`, `busy`, `wr_en`, `rd_en`, `addr`, `wdata`.
  - Reset mid-operation drops the in-flight command; no response is issued for it.
- States: IDLE, WR, RD, POLL, RESP.
- IDLE:
  - `cmd_ready`=1; all bus outputs 0.
  - On accept, latch op, addr, wdata, mask and limit; clear the poll counter.
  - Next state: op 00 -> WR, 01 -> RD, 10 -> POLL, 11 -> RESP with status 10 and rdata 0.
- WR:
  - Exactly one cycle with `wr_en`=1, `addr`/`wdata` = latched values.
  - -> RESP with status 00, rdata 0.
- RD:
  - Exactly one cycle with `rd_en`=1, `addr` = latched address.
  - `rdata` is captured into `rsp_rdata` at the closing edge.
  - -> RESP with status 00.
- POLL:
  - `rd_en`=1 every cycle in this state.
  - At each edge: capture `rdata`, increment the counter.
  - Match is (rdata & mask) == (latched wdata & mask). On match -> RESP, status 00.
  - Else, if counter+1 >= max(limit,1) -> RESP, status 01, rdata = last value read.
  - Else stay in POLL.
  - Match takes priority over timeout on the same read.
  - Counter is TO_W bits wide; it cannot wrap because the limit is also TO_W bits.
- RESP:
  - `rsp_valid`=1; `rsp_rdata`/`rsp_status` held stable while `rsp_ready`=0.
  - On handshake -> IDLE (`rsp_valid` falls at that edge).
  - `cmd_ready`=0 throughout RESP (no overlap of commands).
- Bus outputs are 0 in every cycle the bus is not driven; `wr_en` and `rd_en` are never both 1.
- Latency, with accept at edge E0:
  - Bus cycle is E0..E1.
  - `rsp_valid` is high after E1.
  - With `rsp_ready` tied 1, the next command is accepted at E3.
  - Minimum throughput is 3 cycles per write/read command.
- Poll of N reads: `rsp_valid` is high after edge E0+N.
- `cmd_*` inputs are sampled only at accept; later changes are ignored.

Decomposition:
- Package `reg_bus_pkg`:
  - op codes (OP_WR, OP_RD, OP_POLL, OP_ILL)
  - status codes (ST_OK, ST_TIMEOUT, ST_ILLEGAL)
  - FSM state encoding
  - default ADDR_W/DATA_W
- Single module; no sub-module needed. The poll counter and compare stay inline.

Test Plan (DUT drives a `regset` instance: DATA0 at 0x0 RW, mirror status at 0x4 RO, others read 0):
- Reset, then read 0x0 and read 0x4 -> rsp_rdata 0x00000000, status 00; `rd_en` high exactly one cycle per command.
- Write 0x0 = 0xAAAA5555, then read 0x4 -> `wr_en` one cycle with addr 0x0 and wdata 0xAAAA5555; read returns 0xAAAA5555, status 00; write response rdata 0.
- Poll 0x4, mask 0x0000FFFF, expected 0x00005555, limit 8 -> one read, status 00, rdata 0xAAAA5555. Poll with expected 0x1234, limit 3 -> exactly 3 `rd_en` cycles, status 01, rdata 0xAAAA5555.
- Write 0x4 = 0xFFFFFFFF, then read 0x0 and read 0x100 -> 0xAAAA5555 and 0x00000000; op 11 -> no bus activity, status 10.
- Backpressure: hold `rsp_ready`=0 for 5 cycles after a read -> `rsp_*` stable, `cmd_ready`=0, no bus activity; release -> IDLE next edge.
- Assert `rst` during a poll (`limit` 100) -> all outputs 0 immediately, `cmd_ready`=1 after deassert, no stale `rsp_valid`.
